// File: rtl/bus_control_sequencer.sv
// Moore control sequencer for the shared 32-bit datapath bus: steps each instruction
// through fetch/execute T-states and drives bus selects, load enables and memory strobes.
module bus_control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CW          = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        MDRout,
  output logic        RZLOout,
  output logic        Cout,
  output logic        Rout,
  output logic        MARin,
  output logic        PCin,
  output logic        IncPC,
  output logic        MDRin,
  output logic        IRin,
  output logic        RYin,
  output logic        RZin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        Write,
  output logic [3:0]  alu_op,
  output logic        halted,
  output logic        fault,
  output logic        illegal
);

  localparam int unsigned OPW  = 5;
  localparam int unsigned ALUW = 4;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUW-1:0] ALU_AND = 4'd2;
  localparam logic [ALUW-1:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC,
    S_R3, S_R4, S_R5,
    S_I3, S_I4, S_I5,
    S_M6, S_M7,
    S_HALT, S_FAULT
  } state_t;

  typedef struct packed {
    logic            pc_out;
    logic            mdr_out;
    logic            rzlo_out;
    logic            c_out;
    logic            r_out;
    logic            mar_in;
    logic            pc_in;
    logic            inc_pc;
    logic            mdr_in;
    logic            ir_in;
    logic            ry_in;
    logic            rz_in;
    logic            r_in;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            rd;
    logic            wr;
    logic [ALUW-1:0] alu_op;
    logic            halted;
    logic            fault;
  } ctrl_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]  op_q, op_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic            illegal_q, illegal_d;
  logic            mem_wait;
  logic            timeout;
  logic            op_is_ld;
  logic            op_is_mem;
  logic            ir_unused;

  assign ir_unused = ^ir[26:0];
  assign timeout   = (cnt_q == CW'(MEM_TIMEOUT));
  assign op_is_ld  = (op_q == OP_LD);
  assign op_is_mem = (op_q == OP_LD) || (op_q == OP_ST);

  // Next state, wait counter and latched opcode
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    mem_wait  = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1: begin
        mem_wait = 1'b1;
        if (mem_ready)    state_d = S_F2;
        else if (timeout) state_d = S_FAULT;
      end
      S_F2:   state_d = S_DEC;
      S_DEC: begin
        op_d = ir[31:27];
        case (ir[31:27])
          OP_ADD, OP_SUB, OP_AND, OP_OR:           state_d = S_R3;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LD, OP_ST:  state_d = S_I3;
          OP_NOP:                                  state_d = S_IDLE;
          OP_HALT:                                 state_d = S_HALT;
          default: begin
            state_d   = S_IDLE;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_R3:   state_d = S_R4;
      S_R4:   state_d = S_R5;
      S_R5:   state_d = S_IDLE;
      S_I3:   state_d = S_I4;
      S_I4:   state_d = S_I5;
      S_I5:   state_d = op_is_mem ? S_M6 : S_IDLE;
      S_M6: begin
        if (op_is_ld) begin
          mem_wait = 1'b1;
          if (mem_ready)    state_d = S_M7;
          else if (timeout) state_d = S_FAULT;
        end else begin
          state_d = S_M7;
        end
      end
      S_M7: begin
        if (op_is_ld) begin
          state_d = S_IDLE;
        end else begin
          mem_wait = 1'b1;
          if (mem_ready)    state_d = S_IDLE;
          else if (timeout) state_d = S_FAULT;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    cnt_d = (mem_wait && (state_d == state_q)) ? cnt_q + CW'(1) : '0;
  end

  // Output word for the state being entered; registered so outputs come straight from flops
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_F0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_in = 1'b1;
        ctrl_d.inc_pc = 1'b1;
        ctrl_d.rz_in  = 1'b1;
        ctrl_d.alu_op = ALU_ADD;
      end
      S_F1: begin
        // PC loads only on the entry cycle so a long memory wait increments it once
        ctrl_d.rzlo_out = (state_q != S_F1);
        ctrl_d.pc_in    = (state_q != S_F1);
        ctrl_d.rd       = 1'b1;
        ctrl_d.mdr_in   = 1'b1;
      end
      S_F2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      S_R3, S_I3: begin
        ctrl_d.grb   = 1'b1;
        ctrl_d.r_out = 1'b1;
        ctrl_d.ry_in = 1'b1;
      end
      S_R4: begin
        ctrl_d.grc   = 1'b1;
        ctrl_d.r_out = 1'b1;
        ctrl_d.rz_in = 1'b1;
        case (op_d)
          OP_SUB:  ctrl_d.alu_op = ALU_SUB;
          OP_AND:  ctrl_d.alu_op = ALU_AND;
          OP_OR:   ctrl_d.alu_op = ALU_OR;
          default: ctrl_d.alu_op = ALU_ADD;
        endcase
      end
      S_R5: begin
        ctrl_d.rzlo_out = 1'b1;
        ctrl_d.gra      = 1'b1;
        ctrl_d.r_in     = 1'b1;
      end
      S_I4: begin
        ctrl_d.c_out = 1'b1;
        ctrl_d.rz_in = 1'b1;
        case (op_d)
          OP_ANDI: ctrl_d.alu_op = ALU_AND;
          OP_ORI:  ctrl_d.alu_op = ALU_OR;
          default: ctrl_d.alu_op = ALU_ADD;
        endcase
      end
      S_I5: begin
        ctrl_d.rzlo_out = 1'b1;
        if ((op_d == OP_LD) || (op_d == OP_ST)) begin
          ctrl_d.mar_in = 1'b1;
        end else begin
          ctrl_d.gra  = 1'b1;
          ctrl_d.r_in = 1'b1;
        end
      end
      S_M6: begin
        ctrl_d.mdr_in = 1'b1;
        if (op_d == OP_LD) begin
          ctrl_d.rd = 1'b1;
        end else begin
          ctrl_d.gra   = 1'b1;
          ctrl_d.r_out = 1'b1;
        end
      end
      S_M7: begin
        if (op_d == OP_LD) begin
          ctrl_d.mdr_out = 1'b1;
          ctrl_d.gra     = 1'b1;
          ctrl_d.r_in    = 1'b1;
        end else begin
          ctrl_d.wr = 1'b1;
        end
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      S_FAULT: ctrl_d.fault  = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign PCout   = ctrl_q.pc_out;
  assign MDRout  = ctrl_q.mdr_out;
  assign RZLOout = ctrl_q.rzlo_out;
  assign Cout    = ctrl_q.c_out;
  assign Rout    = ctrl_q.r_out;
  assign MARin   = ctrl_q.mar_in;
  assign PCin    = ctrl_q.pc_in;
  assign IncPC   = ctrl_q.inc_pc;
  assign MDRin   = ctrl_q.mdr_in;
  assign IRin    = ctrl_q.ir_in;
  assign RYin    = ctrl_q.ry_in;
  assign RZin    = ctrl_q.rz_in;
  assign Rin     = ctrl_q.r_in;
  assign Gra     = ctrl_q.gra;
  assign Grb     = ctrl_q.grb;
  assign Grc     = ctrl_q.grc;
  assign Read    = ctrl_q.rd;
  assign Write   = ctrl_q.wr;
  assign alu_op  = ctrl_q.alu_op;
  assign halted  = ctrl_q.halted;
  assign fault   = ctrl_q.fault;
  // Undefined opcode is flagged for the single cycle after decode, as the FSM lands in IDLE
  assign illegal = illegal_q;

endmodule
